// File: rtl/wakeup_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wakeup_issue_ctrl                                               |
// | Brief    : Producer-side issue controller: issue pulse + thermometer delay |
// |            vector, slot table and per-cycle wakeup tag broadcast.          |
// |            Optional stall counter enabled by WAKEUP_STALL_CNT_EN.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module wakeup_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int SLOTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_lat,
  input  logic [TAG_W-1:0] req_tag,
  output logic             issu_en,
  output logic [7:0]       wdy,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [3:0]       inflight
`ifdef WAKEUP_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [SLOTS-1:0] c_one = {{(SLOTS-1){1'b0}}, 1'b1};

  logic [SLOTS-1:0] r_pend;
  logic [2:0]       r_cnt [SLOTS];
  logic [TAG_W-1:0] r_tag [SLOTS];
  logic             r_issu_en;
  logic [7:0]       r_wdy;

  logic [SLOTS-1:0] w_free;
  logic [SLOTS-1:0] w_ready;
  logic [SLOTS-1:0] w_alloc_oh;
  logic [SLOTS-1:0] w_bc_oh;
  logic             w_accept;
  logic [TAG_W-1:0] w_wb_tag;
  logic [3:0]       w_inflight;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot_ready
    assign w_ready[g] = r_pend[g] && (r_cnt[g] == 3'd0);
  end

  // Isolate the lowest set bit: lowest free slot / lowest ready slot wins.
  assign w_free     = ~r_pend;
  assign w_alloc_oh = w_free & (~w_free + c_one);
  assign w_bc_oh    = w_ready & (~w_ready + c_one);

  assign req_ready  = |w_free;
  assign w_accept   = req_valid && req_ready;

  always_comb begin
    w_wb_tag   = '0;
    w_inflight = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_wb_tag   = w_wb_tag | (r_tag[i] & {TAG_W{w_bc_oh[i]}});
      w_inflight = w_inflight + {3'b000, r_pend[i]};
    end
  end

  // Allocation only targets free slots and broadcast only pending ones, so the
  // two never hit the same slot at one edge; a freed slot is reusable next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_cnt[i] <= 3'd0;
        r_tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (w_accept && w_alloc_oh[i]) begin
          r_pend[i] <= 1'b1;
          r_cnt[i]  <= req_lat;
          r_tag[i]  <= req_tag;
        end else if (w_bc_oh[i]) begin
          r_pend[i] <= 1'b0;
        end else if (r_pend[i] && (r_cnt[i] != 3'd0)) begin
          r_cnt[i]  <= r_cnt[i] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issu_en <= 1'b0;
      r_wdy     <= 8'h00;
    end else begin
      r_issu_en <= w_accept;
      r_wdy     <= w_accept ? (8'hFF << req_lat) : 8'h00;
    end
  end

  assign issu_en  = r_issu_en;
  assign wdy      = r_wdy;
  assign wb_valid = |w_ready;
  assign wb_tag   = w_wb_tag;
  assign inflight = w_inflight;

`ifdef WAKEUP_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // An accepted all-ones tag doubles as a debug clear of the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_accept && (&req_tag)) begin
      r_stall_cnt <= 16'h0000;
    end else if (req_valid && !req_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/wakeup_issue_ctrl.md
Name: wakeup_issue_ctrl

Overview:
- Producer-side issue controller that drives the delayed-wakeup interface of the consumer entries.
- Accepts issue requests carrying a destination tag and an execution latency.
- Emits a one-cycle `issu_en` pulse together with the thermometer delay vector `wdy`.
- Tracks each in-flight producer in a small slot table and broadcasts its tag on `wb_valid`/`wb_tag` once its latency elapses.

Parameters:
- TAG_W, 4, width of destination tag.
- SLOTS, 4, number of in-flight producers tracked (2..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  issue request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_lat  in  3  execution latency L, 0..7 cycles.
- req_tag  in  TAG_W  destination tag of the issuing instruction.
- issu_en  out  1  one-cycle issue pulse to consumer entries.
- wdy  out  8  thermometer delay vector, valid while issu_en=1.
- wb_valid  out  1  wakeup broadcast valid.
- wb_tag  out  TAG_W  tag being broadcast.
- inflight  out  4  number of occupied slots.

Behaviour:
- Reset (rst=0, asynchronous): all slots free; issu_en=0, wdy=8'h00, wb_valid=0, wb_tag=0, inflight=0, req_ready=1 once rst deasserts.
- Accept: a request is accepted at a rising edge where req_valid=1 and req_ready=1. req_ready = (a free slot exists). It is combinational from slot state only, never from req_valid.
- Issue output: in the cycle after acceptance, issu_en=1 and wdy = 8'hFF << L. Examples: L=3 gives 8'b11111000; L=0 gives 8'hFF. At all other times issu_en=0 and wdy=8'h00.
- Slot allocation: the lowest-index free slot is loaded with {tag, cnt=L, pend=1}.
- Countdown:
  - Every cycle, each pending slot with cnt>0 decrements by 1.
  - A slot with cnt=0 is ready to broadcast.
- Broadcast:
  - At most one tag per cycle. Among ready slots the lowest index wins.
  - In that cycle wb_valid=1 and wb_tag=slot tag, registered; the slot is freed at that edge.
  - Losing ready slots hold at cnt=0 and broadcast in later cycles in index order.
- Latency: with no contention, wb_valid asserts L+1 cycles after the acceptance edge. L=0 therefore broadcasts in the same cycle as issu_en.
- Simultaneous accept and free: a slot freed by a broadcast at edge E is not reusable at edge E. req_ready reflects occupancy before the edge, so no bypass.
- Full: when all SLOTS slots are occupied, req_ready=0. Requests stall with no loss and no duplicate issue.
- Duplicate tag: a request whose tag matches a pending slot is accepted. Both slots broadcast independently; no merging.
- inflight: count of pending slots after each edge; saturation is impossible (≤SLOTS).
- Reset mid-operation: all pending slots are discarded and no broadcast is emitted for them. Outputs return to reset values immediately.

Optional Feature:
- Macro: WAKEUP_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[15:0]. It increments each cycle where req_valid=1 and req_ready=0, and saturates at 16'hFFFF.
  - Reset value is 0; it is also cleared on an accepted request with req_tag = all ones (debug clear).
- Undefined: no stall_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Single issue: rst low for 20 ns then high; req tag=4'h5, L=3 -> next cycle issu_en=1 with wdy=8'b11111000; wb_valid=1 with wb_tag=5 exactly 4 cycles after acceptance; inflight 1 then 0.
- Zero latency: tag=4'h2, L=0 -> issu_en=1 with wdy=8'hFF and wb_valid=1 with wb_tag=2 in the same cycle.
- Collision: accept tag A with L=2, then tag B with L=1 on the next cycle -> both ready in the same cycle. The lower slot (A) broadcasts first and B on the following cycle; no tag is lost.
- Full stall: 4 back-to-back requests with L=7, then a 5th held valid -> req_ready=0 until the first broadcast frees a slot. The 5th is accepted one edge after that free and issued exactly once.
- Reset mid-flight: 3 pending slots, pulse rst low for 1 ns -> all outputs 0 and inflight=0 immediately; no wb_valid afterwards.
- With WAKEUP_STALL_CNT_EN: hold the 5th request for 10 stall cycles -> stall_cnt=10. Without the macro, the design compiles with no stall_cnt port.
